// File: rtl/sdram_req_arbiter_pkg.sv
// rtl/sdram_req_arbiter_pkg.sv - shared state encoding and burst-length defaults
package sdram_req_arbiter_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_GUARD   = 3'd3;
    localparam logic [2:0] ST_WR_REQ  = 3'd4;
    localparam logic [2:0] ST_WR_DATA = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_RD_REQ  = ST_RD_REQ,
        S_RD_DATA = ST_RD_DATA,
        S_GUARD   = ST_GUARD,
        S_WR_REQ  = ST_WR_REQ,
        S_WR_DATA = ST_WR_DATA
    } arb_state_t;

    localparam int LEN_W      = 9;
    localparam int DEF_RD_LEN = 8;
    localparam int DEF_WR_LEN = 1;

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// rtl/sdram_req_arbiter_if.sv - request/data port between the arbiter and the SDRAM controller core
interface sdram_req_arbiter_if #(
    parameter int AW = 25,
    parameter int DW = 16
);
    import sdram_req_arbiter_pkg::*;

    logic             app_req;
    logic [AW-1:0]    app_req_addr;
    logic [LEN_W-1:0] app_req_len;
    logic             app_req_wr_n;
    logic             app_req_ack;
    logic [DW-1:0]    app_wr_data;
    logic             app_wr_next_req;
    logic             app_rd_valid;
    logic             app_last_rd;
    logic             app_last_wr;

    modport master (
        output app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data,
        input  app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr
    );

    modport slave (
        input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data,
        output app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr
    );

endinterface

// File: rtl/sdram_req_arbiter.sv
// rtl/sdram_req_arbiter.sv - shares the controller request port between video reads and USB writes
module sdram_req_arbiter
    import sdram_req_arbiter_pkg::*;
#(
    parameter int AW            = 25,
    parameter int DW            = 16,
    parameter int RD_LEN        = DEF_RD_LEN,
    parameter int WR_LEN        = DEF_WR_LEN,
    parameter int GUARD         = 2,
    parameter int MAX_RD_STREAK = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                 mem_clk,
    input  logic                 reset_n,
    input  logic                 mem_ready,
    input  logic                 rd_req,
    input  logic [AW-1:0]        rd_addr,
    input  logic                 rd_urgent,
    output logic                 rd_ack,
    input  logic                 wr_req,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    output logic                 wr_ack,
    output logic                 wr_data_next,
    sdram_req_arbiter_if.master  app,
    output logic                 busy,
    output logic                 err
);

    localparam int SW    = $clog2(MAX_RD_STREAK + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GW    = $clog2(GUARD + 1);

    localparam logic [LEN_W-1:0] RD_LEN_F   = LEN_W'(RD_LEN);
    localparam logic [LEN_W-1:0] WR_LEN_F   = LEN_W'(WR_LEN);
    localparam logic [LEN_W-1:0] RD_LAST    = LEN_W'(RD_LEN - 1);
    localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_RD_STREAK);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [GW-1:0]    GUARD_LAST = GW'(GUARD - 1);

    arb_state_t       state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q;
    logic [GW-1:0]    guard_cnt_q;
    logic [SW-1:0]    streak_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [AW-1:0]    addr_q;
    logic [LEN_W-1:0] len_q;
    logic             wr_n_q;
    logic             err_q;

    logic grant_rd, grant_wr, tmo_abort, rd_wins, tmo_state, tmo_hit;

    // Urgent reads always win; otherwise reads may starve a waiting write only MAX_RD_STREAK times
    assign rd_wins   = rd_req && (rd_urgent || !wr_req || (streak_q < STREAK_MAX));
    assign tmo_state = (state_q == S_RD_REQ) || (state_q == S_RD_DATA) ||
                       (state_q == S_WR_REQ) || (state_q == S_WR_DATA);
    assign tmo_hit   = tmo_state && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        tmo_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_ready) begin
                    if (rd_wins) begin
                        state_d  = S_RD_REQ;
                        grant_rd = 1'b1;
                    end else if (wr_req) begin
                        state_d  = S_WR_REQ;
                        grant_wr = 1'b1;
                    end
                end
            end
            S_RD_REQ: begin
                if (app.app_req_ack) state_d = S_RD_DATA;
                else if (tmo_hit)    tmo_abort = 1'b1;
            end
            S_RD_DATA: begin
                if (app.app_rd_valid && (app.app_last_rd || beat_cnt_q == RD_LAST))
                    state_d = S_GUARD;
                else if (tmo_hit)
                    tmo_abort = 1'b1;
            end
            S_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) state_d = S_IDLE;
            end
            S_WR_REQ: begin
                if (app.app_req_ack) state_d = S_WR_DATA;
                else if (tmo_hit)    tmo_abort = 1'b1;
            end
            S_WR_DATA: begin
                if (app.app_last_wr) state_d = S_IDLE;
                else if (tmo_hit)    tmo_abort = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo_abort) state_d = S_IDLE;
    end

    always_ff @(posedge mem_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            guard_cnt_q <= '0;
            streak_q    <= '0;
            tmo_cnt_q   <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            wr_n_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= (tmo_state && state_d == state_q) ? tmo_cnt_q + 1'b1 : '0;
            guard_cnt_q <= (state_q == S_GUARD) ? guard_cnt_q + 1'b1 : '0;
            if (state_q != S_RD_DATA)
                beat_cnt_q <= '0;
            else if (app.app_rd_valid)
                beat_cnt_q <= beat_cnt_q + 1'b1;
            if (grant_rd) begin
                addr_q <= rd_addr;
                len_q  <= RD_LEN_F;
                wr_n_q <= 1'b1;
                if (!wr_req)                  streak_q <= '0;
                else if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
            end else if (grant_wr) begin
                addr_q   <= wr_addr;
                len_q    <= WR_LEN_F;
                wr_n_q   <= 1'b0;
                streak_q <= '0;
            end
            if (tmo_abort) err_q <= 1'b1;
        end
    end

    assign app.app_req      = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign app.app_req_addr = addr_q;
    assign app.app_req_len  = len_q;
    assign app.app_req_wr_n = wr_n_q;
    assign app.app_wr_data  = wr_data;

    assign rd_ack       = (state_q == S_RD_REQ) && app.app_req_ack;
    assign wr_ack       = (state_q == S_WR_REQ) && app.app_req_ack;
    assign wr_data_next = ((state_q == S_WR_REQ) || (state_q == S_WR_DATA)) && app.app_wr_next_req;
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;

endmodule
